usb_in_ep_arbiter: RTL

- Round-robin arbiter that shares the single IN packet buffer port of the USB protocol engine among NUM_EP IN endpoint handlers (control endpoint, CDC ACM notify, CDC bulk TX).
- Sits between the handlers' in_ep_req/grant/put/data/done interface and the engine's buffer write port.
- Grants are registered and held for a whole packet.
- A hold watchdog prevents a stuck handler from locking the buffer.

---
 rtl/usb_arb_pkg.sv | 9 +
 rtl/rr_priority_pick.sv | 23 ++
 rtl/usb_in_ep_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/usb_arb_pkg.sv
// usb_arb_pkg: shared state encoding and owner index width for the USB buffer arbiters
package usb_arb_pkg;
    localparam int OWNER_W = 3;
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick of the first set request at or after ptr
module rr_priority_pick
    import usb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] idx,
    output logic               valid
);
    // scan offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = OWNER_W'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_in_ep_arbiter.sv
// usb_in_ep_arbiter: round-robin owner of the shared IN packet buffer write port with hold watchdog
module usb_in_ep_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NUM_EP   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_EP-1:0]        in_ep_req,
    output logic [NUM_EP-1:0]        in_ep_grant,
    input  logic [NUM_EP-1:0]        in_ep_data_put,
    input  logic [NUM_EP*DATA_W-1:0] in_ep_data,
    input  logic [NUM_EP-1:0]        in_ep_data_done,
    output logic                     buf_data_put,
    output logic [DATA_W-1:0]        buf_data,
    output logic                     buf_data_done,
    output logic                     arb_busy,
    output logic [OWNER_W-1:0]       arb_owner,
    output logic                     arb_timeout,
    output logic                     arb_err
);
    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_EP-1:0]   grant_q, grant_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                timeout_q, timeout_d;
    logic                err_q, err_d;
    logic [OWNER_W-1:0]  pick_idx;
    logic                pick_valid;
    logic                owner_req, owner_put, owner_done, wd_fire;

    rr_priority_pick #(.N(NUM_EP)) u_pick (
        .req   (in_ep_req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_req     = |(in_ep_req & grant_q);
    assign owner_put     = |(in_ep_data_put & grant_q);
    assign owner_done    = |(in_ep_data_done & grant_q);
    assign wd_fire       = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && !owner_put && !owner_done;
    assign buf_data_put  = owner_put;
    assign buf_data_done = owner_done;
    assign in_ep_grant   = grant_q;
    assign arb_busy      = (state_q == ARB_GRANTED);
    assign arb_owner     = owner_q;
    assign arb_timeout   = timeout_q;
    assign arb_err       = err_q;

    // one-hot grant makes the data mux a plain OR of gated lanes
    always_comb begin
        buf_data = '0;
        for (int i = 0; i < NUM_EP; i++) buf_data = buf_data | (grant_q[i] ? in_ep_data[i*DATA_W +: DATA_W] : '0);
    end

    // next-state: pick an owner in IDLE, hold it through the packet, force one empty RELEASE cycle
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        err_d      = |((in_ep_data_put | in_ep_data_done) & ~grant_q);
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_GRANTED;
                    owner_d    = pick_idx;
                    rr_ptr_d   = (pick_idx == OWNER_W'(NUM_EP - 1)) ? '0 : pick_idx + OWNER_W'(1);
                    hold_cnt_d = '0;
                    for (int i = 0; i < NUM_EP; i++) grant_d[i] = (pick_idx == OWNER_W'(i));
                end
            end
            ARB_GRANTED: begin
                hold_cnt_d = owner_put ? '0 : (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
                if (!owner_req || owner_done || wd_fire) begin
                    state_d   = ARB_RELEASE;
                    grant_d   = '0;
                    timeout_d = wd_fire;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // state register; reset drops any grant at once without forwarding a done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end
endmodule
